// File: rtl/work_deserializer.sv
// work_deserializer: assembles 44-byte UART work packets into midstate/data words, discarding stale partial packets
module work_deserializer #(
  parameter int PACKET_BYTES   = 44,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         hash_clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_ready,
  output logic [255:0] midstate,
  output logic [95:0]  data,
  output logic         work_valid,
  output logic         timeout_err,
  output logic [5:0]   byte_count
);
  localparam int BW = PACKET_BYTES * 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [BW-1:0] shift_buf, next_buf;
  logic [TW-1:0] timer;
  logic last, expire;
  always_comb begin
    next_buf = {shift_buf[BW-9:0], rx_data};
    last     = rx_ready && byte_count == 6'(PACKET_BYTES - 1);
    expire   = !rx_ready && byte_count != 6'd0 && timer == TW'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge hash_clk) begin
    if (reset) begin
      midstate    <= '0;
      data        <= '0;
      work_valid  <= 1'b0;
      timeout_err <= 1'b0;
      byte_count  <= '0;
      shift_buf   <= '0;
      timer       <= '0;
    end else begin
      work_valid  <= last;
      timeout_err <= expire;
      if (rx_ready) shift_buf <= next_buf;
      if (last) {midstate, data} <= next_buf;
      byte_count  <= (last || expire) ? 6'd0 : rx_ready ? byte_count + 6'd1 : byte_count;
      timer       <= (rx_ready || expire || byte_count == 6'd0) ? '0 : timer + 1'b1;
    end
  end
endmodule

// File: doc/work_deserializer.md
Name: work_deserializer

Overview:
- Assembles the 44-byte work packet from the UART receive stream into the 256-bit midstate and 96-bit data words consumed by the miner core.
- Sits between async_receiver and the miner core's work registers, in the hash_clk domain.
- Commits a new work unit atomically, signalled by a one-cycle strobe.
- Abandons partial packets after an inter-byte silence so the host can resynchronise.

Parameters:
- PACKET_BYTES, 44, bytes per work packet. Fixed at 32 midstate + 12 data; other values are unsupported.
- TIMEOUT_CYCLES, 2000000, hash_clk cycles of silence after which a partial packet is discarded. Must be ≥ 2.

Ports:
- hash_clk  input  1  sole clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  received byte; valid only when rx_ready = 1.
- rx_ready  input  1  one-cycle strobe per received byte.
- midstate  output  256  committed midstate.
- data  output  96  committed data word.
- work_valid  output  1  one-cycle pulse when midstate/data have just been updated.
- timeout_err  output  1  one-cycle pulse when a partial packet is discarded.
- byte_count  output  6  bytes accepted in the current partial packet, 0..43.

Behaviour:
- Reset (reset = 1 at a clock edge):
  - midstate = 0, data = 0, work_valid = 0, timeout_err = 0.
  - byte_count = 0, shift buffer = 0, silence timer = 0.
  - rx_ready is ignored while reset = 1.
  - Reset mid-packet discards all accepted bytes and does not pulse timeout_err.
- State is implied by byte_count:
  - EMPTY: byte_count = 0.
  - FILLING: byte_count in 1..43.
- Byte acceptance (rx_ready = 1):
  - The 352-bit buffer shifts left by 8 and rx_data enters bits [7:0].
  - The first byte of a packet therefore ends in bits [351:344]; the last byte ends in [7:0].
  - If byte_count < 43: byte_count increments and the silence timer clears.
  - If byte_count = 43 (44th byte), on the same edge:
    - midstate <= {buffer[343:0], rx_data}[351:96] and data <= {buffer[343:0], rx_data}[95:0].
    - work_valid <= 1 and byte_count <= 0.
    - midstate/data/work_valid become visible the cycle after the last rx_ready (latency 1).
- midstate and data are registers.
  - They change only on packet completion or reset.
  - Between completions they hold the previous values; partial packets never disturb them.
- work_valid and timeout_err are high for exactly one cycle, otherwise 0.
- Silence timer:
  - Counts hash_clk cycles while in FILLING with rx_ready = 0; held at 0 in EMPTY.
  - When the timer reaches TIMEOUT_CYCLES−1 with rx_ready = 0:
    - byte_count <= 0 and timer <= 0.
    - timeout_err <= 1 on the next cycle.
    - The buffer contents are don't-care; they are overwritten by the next packet.
- Simultaneous events:
  - rx_ready on the cycle the timer would expire: the byte wins. It is accepted, the timer clears, and there is no timeout.
  - Back-to-back rx_ready on consecutive cycles: every byte is accepted with no gaps required.
  - rx_ready on the cycle work_valid is high: accepted as byte 1 of the next packet.
- Timer width is $clog2(TIMEOUT_CYCLES) bits; no wrap occurs because the timer clears at expiry.
- No backpressure: the block accepts every strobe and has no ready output.

Test Plan:
- Reset behaviour:
  - Stimulus: hold reset 3 cycles, then idle 10 cycles.
  - Required: midstate = 0, data = 0, byte_count = 0; work_valid and timeout_err stay 0.
- Single packet:
  - Stimulus: send bytes 0x00..0x2B with a 5-cycle spacing.
  - Required: byte_count counts 1..43 then returns to 0.
  - Required: work_valid pulses once, 1 cycle after the 44th strobe.
  - Required: midstate = 0x000102…1F, data = 0x202122…2B.
- Back-to-back packets:
  - Stimulus: send 88 consecutive strobes (bytes 0x00..0x57), no gaps.
  - Required: two work_valid pulses 44 cycles apart.
  - Required: final data = 0x4C4D…57.
- Timeout resync (TIMEOUT_CYCLES = 100):
  - Stimulus: send 10 bytes, go silent 100 cycles, then send a full packet of 0xAA bytes.
  - Required: timeout_err pulses once, about 100 cycles after the 10th byte.
  - Required: byte_count returns to 0.
  - Required: the completed work has all bytes = 0xAA; previous midstate is held until that work_valid.
- Boundary race (TIMEOUT_CYCLES = 100):
  - Stimulus: send a byte exactly on the expiry cycle.
  - Required: no timeout_err; byte_count increments.
- Reset mid-packet:
  - Stimulus: assert reset after 20 bytes, then send a full packet.
  - Required: no timeout_err; outputs are 0 after reset.
  - Required: exactly one work_valid, carrying only the post-reset bytes.
